// File: rtl/deca_timer_if.sv
// Command and status bundle between the command logic and deca_timer_ctrl.
// Handshake: there is no valid/ready pair; every command input is a level
// sampled on each rising clk edge and acts on that edge, and every status
// output is a register that is valid for the whole cycle after the edge.
interface deca_timer_if;
  logic       load;
  logic [3:0] ld_tens;
  logic [3:0] ld_units;
  logic       start;
  logic       pause;
  logic       stop;
  logic       auto_reload;
  logic [3:0] tens;
  logic [3:0] units;
  logic [1:0] state;
  logic       running;
  logic       done;
  logic       err;

  modport master (
    output load, ld_tens, ld_units, start, pause, stop, auto_reload,
    input  tens, units, state, running, done, err
  );

  modport slave (
    input  load, ld_tens, ld_units, start, pause, stop, auto_reload,
    output tens, units, state, running, done, err
  );
endinterface

// File: rtl/deca_timer_ctrl.sv
// Two-digit BCD down-counter controller: load/start/pause/stop commands,
// prescaled count tick, terminal-count detection and optional auto-reload.
module deca_timer_ctrl #(
  parameter int TICK_DIV = 4,
  parameter int PW       = 8
) (
  input logic         clk,
  input logic         clear,
  deca_timer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  state_t        st;
  logic [3:0]    tens_q;
  logic [3:0]    units_q;
  logic [3:0]    rl_tens;
  logic [3:0]    rl_units;
  logic [PW-1:0] presc;
  logic          done_q;
  logic          err_q;

  logic          ld_ok;
  logic          tick;
  logic [3:0]    dec_tens;
  logic [3:0]    dec_units;
  logic          dec_zero;
  logic [3:0]    src_tens;
  logic [3:0]    src_units;
  logic          src_zero;

  assign ld_ok = (bus.ld_tens <= 4'd9) && (bus.ld_units <= 4'd9);
  assign tick  = (presc == TICK_LAST);

  // Decade decrement of the current count and the terminal-count flag.
  always_comb begin
    dec_tens  = tens_q;
    dec_units = units_q;
    if (units_q != 4'd0) begin
      dec_units = units_q - 4'd1;
    end else begin
      dec_units = 4'd9;
      dec_tens  = tens_q - 4'd1;
    end
    dec_zero = (tens_q == 4'd0) && (units_q == 4'd1);
  end

  // Count that a start uses: DONE restarts from the reload value.
  always_comb begin
    src_tens  = tens_q;
    src_units = units_q;
    if (st == S_DONE) begin
      src_tens  = rl_tens;
      src_units = rl_units;
    end
    src_zero = (src_tens == 4'd0) && (src_units == 4'd0);
  end

  // Command sequencer, prescaler and digit registers; priority
  // clear > stop > load > pause > start, then the RUN tick.
  always_ff @(posedge clk) begin
    if (clear) begin
      st       <= S_IDLE;
      tens_q   <= 4'd0;
      units_q  <= 4'd0;
      rl_tens  <= 4'd0;
      rl_units <= 4'd0;
      presc    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (bus.stop) begin
        st      <= S_IDLE;
        tens_q  <= rl_tens;
        units_q <= rl_units;
        presc   <= '0;
      end else if (bus.load) begin
        if ((st == S_RUN) || !ld_ok) begin
          // Rejected load freezes everything for this cycle.
          err_q <= 1'b1;
        end else begin
          st       <= S_IDLE;
          tens_q   <= bus.ld_tens;
          units_q  <= bus.ld_units;
          rl_tens  <= bus.ld_tens;
          rl_units <= bus.ld_units;
          presc    <= '0;
        end
      end else if (bus.pause && (st == S_RUN)) begin
        st <= S_PAUSE;
      end else if (bus.start && ((st == S_IDLE) || (st == S_DONE))) begin
        tens_q  <= src_tens;
        units_q <= src_units;
        presc   <= '0;
        if (src_zero) begin
          // A zero count would loop with period zero; finish at once.
          st     <= S_DONE;
          done_q <= 1'b1;
        end else begin
          st <= S_RUN;
        end
      end else if (bus.start && (st == S_PAUSE)) begin
        st <= S_RUN;
      end else if (st == S_RUN) begin
        if (tick) begin
          presc <= '0;
          if (dec_zero) begin
            done_q <= 1'b1;
            if (bus.auto_reload) begin
              tens_q  <= rl_tens;
              units_q <= rl_units;
            end else begin
              tens_q  <= 4'd0;
              units_q <= 4'd0;
              st      <= S_DONE;
            end
          end else begin
            tens_q  <= dec_tens;
            units_q <= dec_units;
          end
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

  assign bus.tens    = tens_q;
  assign bus.units   = units_q;
  assign bus.state   = st;
  assign bus.running = (st == S_RUN);
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule

// File: doc/deca_timer_ctrl.md
Name: deca_timer_ctrl

Overview:
- Controller that sequences a two-digit BCD down-counter (00-99) built on the team's decade decrement datapath.
- Handles load/start/pause/stop commands, prescales the count tick, detects terminal count and optionally auto-reloads.
- Sits between the command logic (main/bench) and the counter digits. Exposes digit values, status flags and a one-cycle done pulse.

Parameters:
- TICK_DIV, 4, clk cycles per count decrement in RUN; legal range 1..255.
- PW, 8, prescaler width in bits; must satisfy 2^PW >= TICK_DIV.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- clear  in  1  reset, synchronous, active-high.
- load  in  1  latch ld_tens/ld_units as the new reload value and count.
- ld_tens  in  4  BCD tens digit to load.
- ld_units  in  4  BCD units digit to load.
- start  in  1  begin counting (IDLE) or resume (PAUSE).
- pause  in  1  freeze counting (RUN).
- stop  in  1  abort to IDLE and restore the reload value.
- auto_reload  in  1  at terminal count, reload and keep running instead of stopping.
- tens  out  4  current tens digit.
- units  out  4  current units digit.
- state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.
- running  out  1  high while state==RUN.
- done  out  1  one-cycle pulse at terminal count.
- err  out  1  one-cycle pulse on a rejected command.

Behaviour:
- Reset: clear is sampled on posedge clk only; it overrides every other input. After the reset edge: state=IDLE, tens=0, units=0, reload register=00, prescaler=0, running=0, done=0, err=0.
- Command priority per cycle: clear > stop > load > pause > start.
- All outputs are registered. Commands are level-sampled and take effect on the next edge.
- stop (any state): state->IDLE, tens/units<=reload register, prescaler<=0.
- load:
  - Accepted in IDLE, PAUSE and DONE when both digits are <=9. Count and reload register take the new value, prescaler<=0, state->IDLE.
  - A digit >9, or load while in RUN: command ignored, err=1 for one cycle, state and count unchanged.
- start in IDLE or DONE:
  - Count!=00: state->RUN, prescaler<=0. In DONE, the count is first restored from the reload register.
  - Count==00 (after any restore): state->DONE, done=1 for one cycle.
- start in PAUSE: state->RUN; prescaler keeps its frozen value.
- start in RUN: no effect.
- pause in RUN: state->PAUSE; prescaler and digits hold.
- pause in other states: no effect.
- Simultaneous pause+start in RUN: pause wins.
- RUN tick:
  - Prescaler increments each cycle. At the edge where prescaler==TICK_DIV-1, the prescaler returns to 0 and the count decrements.
  - With start sampled at edge E0, the first decrement occurs at edge E(TICK_DIV). If TICK_DIV=1, the count decrements every cycle.
- Decrement rule: if units!=0, units-1. Otherwise units<=9 and tens-1. Digits never leave 0-9.
- Terminal count, on a decrement that produces 00:
  - auto_reload=0: count shows 00, state->DONE, running=0, done=1 for one cycle.
  - auto_reload=1: count<=reload register in that same edge (00 is never displayed), done=1 for one cycle, stays RUN, prescaler restarts at 0.
- Reload value 00 with auto_reload=1: start goes straight to DONE. This prevents a zero-period loop.
- DONE holds the 00 count until stop, load or start.
- Reset mid-RUN: the next edge gives IDLE with count 00. The reload register is also cleared.

Test Plan:
- clear=1 for 2 cycles, then release -> state=0, tens=0, units=0, done=0, err=0, running=0.
- TICK_DIV=4: load 03, start at E0 -> units=2 after E4, 1 after E8, 0 after E12. done=1 only in the cycle after E12, then state=3, running=0.
- load 10, start -> digits 1,0 then 0,9 after 4 cycles. Continue to 00; verify no digit ever exceeds 9.
- auto_reload=1, load 02, run 3 decrement periods -> sequence 02,01,02,01. done pulses once per wrap; 00 is never displayed; state stays 1.
- Load 05, start, pause after 6 cycles -> count frozen at 04 for 10 cycles. Then start resumes: the remaining prescaler phase gives 03 two cycles later.
- load with ld_units=12 -> err pulse, count unchanged. load during RUN -> err pulse. clear during RUN -> IDLE, 00 next edge. stop+start same cycle -> IDLE with reload value.
